be_unit: RTL and testbench

//   MEM-stage byte-enable generator for the 5-stage MIPS pipeline.
//   - Decodes the store instruction held in IR_M together with the low bits of MemAddr.
//   - Drives the 4-bit data-memory byte-enable m_data_byteen and the lane-aligned write data.
//   - Sits between the M pipeline register and the external data-memory port.

---
 rtl/be_pkg.sv | 19 +
 rtl/be_decode.sv | 19 +
 rtl/be_unit.sv | 78 +++++++
 tb/tb_be_unit.sv | 128 ++++++++++++
 4 files changed

// File: rtl/be_pkg.sv
// Shared opcodes, access-size encoding and byte-enable constants for the MEM-stage
// byte-enable generator.
package be_pkg;

    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    typedef enum logic [1:0] {
        ACC_NONE,
        ACC_BYTE,
        ACC_HALF,
        ACC_WORD
    } acc_size_e;

    localparam logic [3:0] BYTEEN_NONE = 4'b0000;
    localparam logic [3:0] BYTEEN_ALL  = 4'b1111;

endpackage

// File: rtl/be_decode.sv
// Store-opcode decoder: maps IR_M[31:26] to the access size of the memory write.
module be_decode
    import be_pkg::*;
(
    input  logic [5:0] opcode,
    output acc_size_e  acc_size
);

    always_comb begin
        acc_size = ACC_NONE;
        case (opcode)
            OP_SW:   acc_size = ACC_WORD;
            OP_SH:   acc_size = ACC_HALF;
            OP_SB:   acc_size = ACC_BYTE;
            default: acc_size = ACC_NONE;
        endcase
    end

endmodule

// File: rtl/be_unit.sv
// MEM-stage byte-enable and lane-aligned write-data generator.
// Optional alignment checking (misalign / misalign_sticky) under macro BE_ALIGN_CHECK_EN.
module be_unit
    import be_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] IR_M,
    input  logic [31:0] MemAddr,
    input  logic [31:0] WD_M,
    output logic [3:0]  m_data_byteen,
    output logic [31:0] m_data_wdata
`ifdef BE_ALIGN_CHECK_EN
    ,
    output logic        misalign,
    output logic        misalign_sticky
`endif
);

    acc_size_e  acc_size;
    logic [3:0] lane_mask;

    // Only the opcode field and the low address bits take part in the decode.
    logic unused_bits;
    assign unused_bits = ^{clk, IR_M[25:0], MemAddr[31:2]};

    be_decode u_decode (
        .opcode   (IR_M[31:26]),
        .acc_size (acc_size)
    );

    always_comb begin
        lane_mask    = BYTEEN_NONE;
        m_data_wdata = '0;
        case (acc_size)
            ACC_WORD: begin
                lane_mask    = BYTEEN_ALL;
                m_data_wdata = WD_M;
            end
            ACC_HALF: begin
                lane_mask    = MemAddr[1] ? 4'b1100 : 4'b0011;
                m_data_wdata = {2{WD_M[15:0]}};
            end
            ACC_BYTE: begin
                lane_mask    = 4'b0001 << MemAddr[1:0];
                m_data_wdata = {4{WD_M[7:0]}};
            end
            default: begin
                lane_mask    = BYTEEN_NONE;
                m_data_wdata = '0;
            end
        endcase
    end

`ifdef BE_ALIGN_CHECK_EN
    always_comb begin
        misalign = 1'b0;
        case (acc_size)
            ACC_WORD: misalign = (MemAddr[1:0] != 2'b00);
            ACC_HALF: misalign = MemAddr[0];
            default:  misalign = 1'b0;
        endcase
    end

    assign m_data_byteen = (reset || misalign) ? BYTEEN_NONE : lane_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_sticky <= 1'b0;
        end else if (misalign) begin
            misalign_sticky <= 1'b1;
        end
    end
`else
    assign m_data_byteen = reset ? BYTEEN_NONE : lane_mask;
`endif

endmodule

// File: tb/tb_be_unit.sv
// Self-checking bench for be_unit: directed cases plus randomized stores against a
// behavioural model; also covers BE_ALIGN_CHECK_EN builds.
module tb_be_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] IR_M;
    logic [31:0] MemAddr;
    logic [31:0] WD_M;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_data_wdata;
`ifdef BE_ALIGN_CHECK_EN
    logic        misalign;
    logic        misalign_sticky;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic        exp_sticky = 1'b0;

    always #5 clk = ~clk;

    be_unit dut (
        .clk           (clk),
        .reset         (reset),
        .IR_M          (IR_M),
        .MemAddr       (MemAddr),
        .WD_M          (WD_M),
        .m_data_byteen (m_data_byteen),
        .m_data_wdata  (m_data_wdata)
`ifdef BE_ALIGN_CHECK_EN
        ,
        .misalign        (misalign),
        .misalign_sticky (misalign_sticky)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference behaviour computed from the store rules with plain arithmetic.
    function automatic void ref_model(input logic [31:0] ir, input logic [31:0] addr,
                                      input logic [31:0] wd, input logic rst,
                                      output logic [3:0] be, output logic [31:0] wdv,
                                      output logic mis);
        int unsigned op  = ir[31:26];
        int unsigned off = addr % 4;
        be  = 0;
        wdv = 0;
        mis = 0;
        if (op == 43) begin
            be = 15; wdv = wd; mis = (off != 0);
        end else if (op == 41) begin
            be = (off >= 2) ? 12 : 3;
            wdv = (wd % 65536) * 32'h0001_0001;
            mis = (off % 2 == 1);
        end else if (op == 40) begin
            be = 4'(2 ** off);
            wdv = (wd % 256) * 32'h0101_0101;
        end
`ifdef BE_ALIGN_CHECK_EN
        if (mis) be = 0;
`endif
        if (rst) be = 0;
    endfunction

    // Drive one cycle, check combinational outputs mid-cycle and the sticky flag after the edge.
    task automatic step(input string tag, input logic [31:0] ir, input logic [31:0] addr,
                        input logic [31:0] wd, input logic rst);
        logic [3:0]  be;
        logic [31:0] wdv;
        logic        mis;
        @(negedge clk);
        IR_M = ir; MemAddr = addr; WD_M = wd; reset = rst;
        ref_model(ir, addr, wd, rst, be, wdv, mis);
        #1;
        check_eq({tag, ".byteen"}, 32'(m_data_byteen), 32'(be));
        if (!rst) check_eq({tag, ".wdata"}, m_data_wdata, wdv);
`ifdef BE_ALIGN_CHECK_EN
        check_eq({tag, ".misalign"}, 32'(misalign), 32'(mis));
`endif
        @(posedge clk);
        if (rst) exp_sticky = 1'b0;
        else if (mis) exp_sticky = 1'b1;
        #1;
`ifdef BE_ALIGN_CHECK_EN
        check_eq({tag, ".sticky"}, 32'(misalign_sticky), 32'(exp_sticky));
`endif
    endtask

    initial begin
        logic [31:0] ops [5];
        ops[0] = 32'hAC00_0000; ops[1] = 32'hA400_0000; ops[2] = 32'hA000_0000;
        ops[3] = 32'h8C00_0000; ops[4] = 32'h0000_0000;
        reset = 1'b1; IR_M = '0; MemAddr = '0; WD_M = '0;

        step("reset", 32'h0, 32'h0, 32'h0, 1'b1);
        step("sw", 32'hAC00_0000, 32'h0000_1000, 32'h1234_5678, 1'b0);
        step("sh_hi", 32'hA400_0000, 32'h0000_0002, 32'hAAAA_BEEF, 1'b0);
        step("sh_lo", 32'hA400_0000, 32'h0000_0000, 32'hAAAA_BEEF, 1'b0);
        for (int i = 0; i < 4; i++)
            step("sb_sweep", 32'hA000_0000, 32'(i), 32'h0000_00C3, 1'b0);
        step("lw", 32'h8C00_0000, 32'h0000_0004, 32'hFFFF_FFFF, 1'b0);
        step("nop", 32'h0, 32'h0000_0003, 32'hFFFF_FFFF, 1'b0);
        step("sw_mis", 32'hAC00_0000, 32'h0000_0001, 32'hDEAD_BEEF, 1'b0);
        step("sh_mis", 32'hA400_0000, 32'h0000_0003, 32'hDEAD_BEEF, 1'b0);
        step("sw_after_mis", 32'hAC00_0000, 32'h0000_0008, 32'hCAFE_F00D, 1'b0);
        step("rst_sw", 32'hAC00_0000, 32'h0000_0000, 32'h1111_2222, 1'b1);
        step("post_rst_sw", 32'hAC00_0000, 32'h0000_0000, 32'h1111_2222, 1'b0);
        step("hi_addr_ignored", 32'hA000_0000, 32'hFFFF_FFFE, 32'h1234_56A5, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] ir;
            int unsigned k = $urandom_range(0, 5);
            ir = (k < 5) ? (ops[k] | ($urandom & 32'h03FF_FFFF)) : $urandom;
            step("rand", ir, $urandom, $urandom, ($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
